// File: rtl/alu_dispatch_if.sv
// rtl/alu_dispatch_if.sv - request/response handshake bundle for alu_dispatch
interface alu_dispatch_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_instr;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;

    modport slave (
        input  req_valid, req_instr, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_err
    );

    modport master (
        output req_valid, req_instr, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/alu_dispatch.sv
// rtl/alu_dispatch.sv - one-at-a-time dispatcher around a combinational ALU
// Optional illegal-instruction bypass enabled by ALU_DISPATCH_ILLEGAL_CHK_EN.
module alu_dispatch #(
    parameter int MUL_LAT = 2,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_dispatch_if.slave    bus,
    output logic [31:0]      alu_in1,
    output logic [31:0]      alu_in2,
    output logic [31:0]      alu_instr,
    input  logic [31:0]      alu_out,
    output logic [CNT_W-1:0] done_cnt
);
    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

    localparam logic [3:0] OP_MUL   = 4'b0010;
    localparam logic [3:0] MUL_LOAD = 4'(MUL_LAT);

    state_t           state_q, state_d;
    logic [3:0]       wait_q, wait_d;
    logic             req_ready_q, req_ready_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_err_q, rsp_err_d;
    logic [31:0]      rsp_data_q, rsp_data_d;
    logic [31:0]      in1_q, in1_d;
    logic [31:0]      in2_q, in2_d;
    logic [31:0]      instr_q, instr_d;
    logic [CNT_W-1:0] done_q, done_d;
    logic             skip;

    always_comb begin
`ifdef ALU_DISPATCH_ILLEGAL_CHK_EN
        skip = (bus.req_instr[27:24] > 4'b0101) || (bus.req_instr[2:0] > 3'b011);
`else
        skip = 1'b0;
`endif
    end

    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rsp_data_d  = rsp_data_q;
        in1_d       = in1_q;
        in2_d       = in2_q;
        instr_d     = instr_q;
        done_d      = done_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid && req_ready_q) begin
                    req_ready_d = 1'b0;
                    if (skip) begin
                        // Rejected requests never reach the ALU, so alu_* keep the last operands.
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = 32'd0;
                        rsp_err_d   = 1'b1;
                    end else begin
                        in1_d   = bus.req_a;
                        in2_d   = bus.req_b;
                        instr_d = bus.req_instr;
                        wait_d  = (bus.req_instr[27:24] == OP_MUL) ? MUL_LOAD : 4'd1;
                        state_d = EXEC;
                    end
                end
            end
            EXEC: begin
                if (wait_q <= 4'd1) begin
                    wait_d      = 4'd0;
                    rsp_data_d  = alu_out;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    state_d     = RESP;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    rsp_err_d   = 1'b0;
                    req_ready_d = 1'b1;
                    if (done_q != {CNT_W{1'b1}}) begin
                        done_d = done_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wait_q      <= 4'd0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= 32'd0;
            in1_q       <= 32'd0;
            in2_q       <= 32'd0;
            instr_q     <= 32'd0;
            done_q      <= '0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_data_q  <= rsp_data_d;
            in1_q       <= in1_d;
            in2_q       <= in2_d;
            instr_q     <= instr_d;
            done_q      <= done_d;
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;
    assign alu_in1       = in1_q;
    assign alu_in2       = in2_q;
    assign alu_instr     = instr_q;
    assign done_cnt      = done_q;
endmodule
